// File: rtl/sweep_store_pkg.sv
// Shared constants, types and layout helper for the sweep ring and its
// downstream averaging stage.
package sweep_store_pkg;

  localparam int DW     = 12;
  localparam int SWEEPS = 10;

  typedef logic [DW-1:0] point_t;

  typedef enum logic {
    S_WAIT,
    S_FILL
  } state_e;

  // Bit base of slot k, point p in the flat storage vector (slot 0 at LSBs).
  function automatic int unsigned slot_offset(input int unsigned k,
                                              input int unsigned p,
                                              input int unsigned points);
    return DW * points * k + DW * p;
  endfunction

endpackage

// File: rtl/sweep_store_if.sv
// Upstream sample handshake: valid/first/data forward, ready backward.
interface sweep_store_if;
  import sweep_store_pkg::*;

  logic   in_valid;
  logic   in_first;
  point_t in_data;
  logic   in_ready;

  modport master (output in_valid, output in_first, output in_data, input in_ready);
  modport slave  (input in_valid, input in_first, input in_data, output in_ready);

endinterface

// File: rtl/sweep_ring_ctrl.sv
// Sweep framing FSM, slot/point counters and fill tracking; emits the
// write strobe and word coordinates for the ring storage.
module sweep_ring_ctrl
  import sweep_store_pkg::*;
#(
  parameter int POINTS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        accept_i,
  input  logic        first_i,
  input  logic        clear_i,
  output logic        we_o,
  output logic [3:0]  wslot_o,
  output logic [10:0] wpoint_o,
  output logic [3:0]  cnt_slot_o,
  output logic [10:0] cnt_point_o,
  output logic [3:0]  filled_o,
  output logic        all_valid_o,
  output logic        sweep_done_o,
  output logic        sync_err_o
);

  localparam logic [10:0] LAST_PT   = 11'(POINTS - 1);
  localparam logic [3:0]  LAST_SLOT = 4'(SWEEPS - 1);
  localparam logic [3:0]  FULL      = 4'(SWEEPS);

  state_e      state_q, state_d;
  logic [10:0] point_q, point_d;
  logic [3:0]  slot_q, slot_d;
  logic [3:0]  filled_q, filled_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        we;
  logic [10:0] wpoint;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_WAIT;
      point_q  <= '0;
      slot_q   <= '0;
      filled_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      point_q  <= point_d;
      slot_q   <= slot_d;
      filled_q <= filled_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    point_d  = point_q;
    slot_d   = slot_q;
    filled_d = filled_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    we       = 1'b0;
    wpoint   = point_q;
    if (clear_i) begin
      state_d  = S_WAIT;
      point_d  = '0;
      slot_d   = '0;
      filled_d = '0;
    end else if (accept_i) begin
      case (state_q)
        S_WAIT: begin
          if (first_i) begin
            we     = 1'b1;
            wpoint = '0;
          end
        end
        S_FILL: begin
          we = 1'b1;
          // A restart mid-sweep throws away the partial data in this slot.
          if (first_i && point_q != '0) begin
            err_d  = 1'b1;
            wpoint = '0;
          end
        end
        default: ;
      endcase
      if (we) begin
        state_d = S_FILL;
        if (wpoint == LAST_PT) begin
          point_d  = '0;
          slot_d   = (slot_q == LAST_SLOT) ? 4'd0 : slot_q + 4'd1;
          filled_d = (filled_q == FULL) ? filled_q : filled_q + 4'd1;
          done_d   = 1'b1;
        end else begin
          point_d = wpoint + 11'd1;
        end
      end
    end
  end

  assign we_o         = we;
  assign wslot_o      = slot_q;
  assign wpoint_o     = wpoint;
  assign cnt_slot_o   = slot_q;
  assign cnt_point_o  = point_q;
  assign filled_o     = filled_q;
  assign all_valid_o  = (filled_q == FULL);
  assign sweep_done_o = done_q;
  assign sync_err_o   = err_q;

endmodule

// File: rtl/sweep_store.sv
// Ten-slot sweep ring buffer presenting its contents as one flat vector
// in the layout the averaging stage indexes.
module sweep_store
  import sweep_store_pkg::*;
#(
  parameter int POINTS = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  sweep_store_if.slave                bus,
  input  logic                        freeze,
  input  logic                        clear,
  output logic [DW*POINTS*SWEEPS-1:0] storage,
  output logic [3:0]                  cnt_slot,
  output logic [10:0]                 cnt_point,
  output logic [3:0]                  filled,
  output logic                        all_valid,
  output logic                        sweep_done,
  output logic                        sync_err
);

  localparam int SW = DW * POINTS * SWEEPS;
  localparam int IW = $clog2(SW);

  logic          accept;
  logic          we;
  logic [3:0]    wslot;
  logic [10:0]   wpoint;
  logic [IW-1:0] wbase;
  logic [SW-1:0] storage_q, storage_d;

  assign bus.in_ready = !freeze && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  sweep_ring_ctrl #(
    .POINTS(POINTS)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .accept_i    (accept),
    .first_i     (bus.in_first),
    .clear_i     (clear),
    .we_o        (we),
    .wslot_o     (wslot),
    .wpoint_o    (wpoint),
    .cnt_slot_o  (cnt_slot),
    .cnt_point_o (cnt_point),
    .filled_o    (filled),
    .all_valid_o (all_valid),
    .sweep_done_o(sweep_done),
    .sync_err_o  (sync_err)
  );

  assign wbase = IW'(slot_offset(32'(wslot), 32'(wpoint), POINTS));

  always_comb begin
    storage_d = storage_q;
    if (we) storage_d[wbase +: DW] = bus.in_data;
  end

  // clear leaves data in place; filled = 0 marks it stale.
  always_ff @(posedge clk) begin
    if (rst) storage_q <= '0;
    else     storage_q <= storage_d;
  end

  assign storage = storage_q;

endmodule

// File: tb/tb_sweep_store.sv
// Bench for sweep_store with POINTS = 4: vector table plus sequences, and a
// scoreboard that checks each completed slot when sweep_done pulses.
module tb_sweep_store;
  import sweep_store_pkg::*;

  localparam int P  = 4;
  localparam int SW = DW * P * SWEEPS;

  logic          clk = 1'b0;
  logic          rst, freeze, clear;
  logic [SW-1:0] storage;
  logic [3:0]    cnt_slot, filled;
  logic [10:0]   cnt_point;
  logic          all_valid, sweep_done, sync_err;

  sweep_store_if u_if();

  sweep_store #(.POINTS(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (u_if),
    .freeze    (freeze),
    .clear     (clear),
    .storage   (storage),
    .cnt_slot  (cnt_slot),
    .cnt_point (cnt_point),
    .filled    (filled),
    .all_valid (all_valid),
    .sweep_done(sweep_done),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  slot;
    logic [47:0] words;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic        v, f, frz, clr;
    logic [11:0] d;
    logic        rdy;
    logic [10:0] pt;
    logic [3:0]  slot, fil;
    logic        done, err;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] word(input int k, input int p);
    logic [SW-1:0] t;
    t = storage >> (48 * k + 12 * p);
    return t[11:0];
  endfunction

  function automatic logic [47:0] slot_words(input int k);
    logic [SW-1:0] t;
    t = storage >> (48 * k);
    return t[47:0];
  endfunction

  function automatic logic [47:0] sw_words(input int s);
    logic [47:0] w;
    w = '0;
    for (int p = 0; p < P; p++) w = w | (48'(16 * s + p) << (12 * p));
    return w;
  endfunction

  task automatic addv(input int v, input int f, input int frz, input int clr, input int d,
                      input int rdy, input int pt, input int slot, input int fil,
                      input int done, input int err);
    vec_t e;
    e.v = v[0]; e.f = f[0]; e.frz = frz[0]; e.clr = clr[0]; e.d = d[11:0];
    e.rdy = rdy[0]; e.pt = pt[10:0]; e.slot = slot[3:0]; e.fil = fil[3:0];
    e.done = done[0]; e.err = err[0];
    vq.push_back(e);
  endtask

  task automatic push_sb(input int slot, input logic [47:0] w);
    sb_t e;
    e.slot  = slot[3:0];
    e.words = w;
    sbq.push_back(e);
  endtask

  task automatic cyc(input logic v, input logic f, input logic [11:0] d);
    u_if.in_valid = v;
    u_if.in_first = f;
    u_if.in_data  = d;
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    u_if.in_first = 1'b0;
  endtask

  task automatic sweep(input int s, input int slot);
    push_sb(slot, sw_words(s));
    for (int p = 0; p < P; p++) cyc(1'b1, p == 0, 12'(16 * s + p));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  sb_t mon_e;
  always @(negedge clk) begin
    if (sweep_done) begin
      chk("sb_pending", 64'(sbq.size() > 0), 64'd1);
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk($sformatf("sb_slot%0d", mon_e.slot), 64'(slot_words(int'(mon_e.slot))),
            64'(mon_e.words));
      end
    end
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; clear = 1'b0;
    u_if.in_valid = 1'b1; u_if.in_first = 1'b0; u_if.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(u_if.in_ready), 64'd0);
    rst = 1'b0;
    u_if.in_valid = 1'b0;
    chk("rst_point",  64'(cnt_point), 64'd0);
    chk("rst_slot",   64'(cnt_slot), 64'd0);
    chk("rst_filled", 64'(filled), 64'd0);
    chk("rst_allv",   64'(all_valid), 64'd0);
    chk("rst_done",   64'(sweep_done), 64'd0);
    chk("rst_err",    64'(sync_err), 64'd0);
    chk("rst_stor",   64'(|storage), 64'd0);

    // Discard before first, first sweep, sync error, free-running start, freeze.
    push_sb(0, 48'h004003002001);
    push_sb(1, 48'h204203202201);
    push_sb(2, 48'h304303302301);
    addv(1,0,0,0,'h0AA, 1, 0,0,0,0,0);
    addv(1,0,0,0,'h0BB, 1, 0,0,0,0,0);
    addv(0,0,0,0,'h000, 1, 0,0,0,0,0);
    addv(1,1,0,0,'h001, 1, 1,0,0,0,0);
    addv(1,0,0,0,'h002, 1, 2,0,0,0,0);
    addv(0,0,0,0,'h0FF, 1, 2,0,0,0,0);
    addv(1,0,0,0,'h003, 1, 3,0,0,0,0);
    addv(1,0,0,0,'h004, 1, 0,1,1,1,0);
    addv(0,0,0,0,'h000, 1, 0,1,1,0,0);
    addv(1,1,0,0,'h101, 1, 1,1,1,0,0);
    addv(1,0,0,0,'h102, 1, 2,1,1,0,0);
    addv(1,1,0,0,'h201, 1, 1,1,1,0,1);
    addv(1,0,0,0,'h202, 1, 2,1,1,0,0);
    addv(1,0,0,0,'h203, 1, 3,1,1,0,0);
    addv(1,0,0,0,'h204, 1, 0,2,2,1,0);
    addv(1,0,0,0,'h301, 1, 1,2,2,0,0);
    addv(1,0,0,0,'h302, 1, 2,2,2,0,0);
    for (int i = 0; i < 5; i++) addv(1,0,1,0,'h3FF, 0, 2,2,2,0,0);
    addv(1,0,0,0,'h303, 1, 3,2,2,0,0);
    addv(1,0,0,0,'h304, 1, 0,3,3,1,0);

    for (int i = 0; i < vq.size(); i++) begin
      u_if.in_valid = vq[i].v;
      u_if.in_first = vq[i].f;
      u_if.in_data  = vq[i].d;
      freeze        = vq[i].frz;
      clear         = vq[i].clr;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(u_if.in_ready), 64'(vq[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_point", i), 64'(cnt_point), 64'(vq[i].pt));
      chk($sformatf("v%0d_slot", i), 64'(cnt_slot), 64'(vq[i].slot));
      chk($sformatf("v%0d_filled", i), 64'(filled), 64'(vq[i].fil));
      chk($sformatf("v%0d_done", i), 64'(sweep_done), 64'(vq[i].done));
      chk($sformatf("v%0d_err", i), 64'(sync_err), 64'(vq[i].err));
    end
    u_if.in_valid = 1'b0; freeze = 1'b0; clear = 1'b0;
    chk("t1_slot0", 64'(storage[47:0]), 64'h004003002001);
    chk("t1_slot3_untouched", 64'(slot_words(3)), 64'd0);

    // Twelve full sweeps: wrap and overwrite.
    do_reset();
    chk("t2_stor_zero", 64'(|storage), 64'd0);
    for (int s = 0; s < 12; s++) begin
      sweep(s, s % 10);
      chk($sformatf("t2_filled_s%0d", s), 64'(filled), 64'((s + 1 > 10) ? 10 : s + 1));
      chk($sformatf("t2_allv_s%0d", s), 64'(all_valid), 64'(s >= 9));
    end
    chk("t2_slot", 64'(cnt_slot), 64'd2);
    chk("t2_slot0", 64'(slot_words(0)), 64'(sw_words(10)));
    chk("t2_slot1", 64'(slot_words(1)), 64'(sw_words(11)));
    chk("t2_slot2", 64'(slot_words(2)), 64'(sw_words(2)));

    // clear with a sample in the same cycle, ring full.
    cyc(1'b1, 1'b1, 12'h0E1);
    cyc(1'b1, 1'b0, 12'h0E2);
    u_if.in_valid = 1'b1; u_if.in_first = 1'b0; u_if.in_data = 12'h0EE; clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0; u_if.in_valid = 1'b0;
    chk("clr_filled", 64'(filled), 64'd0);
    chk("clr_allv",   64'(all_valid), 64'd0);
    chk("clr_slot",   64'(cnt_slot), 64'd0);
    chk("clr_point",  64'(cnt_point), 64'd0);
    chk("clr_dropped", 64'(word(2, 2)), 64'h022);
    chk("clr_held",    64'(word(2, 0)), 64'h0E1);
    cyc(1'b1, 1'b0, 12'h0AB);
    chk("clr_wait_point", 64'(cnt_point), 64'd0);
    chk("clr_wait_data",  64'(word(0, 0)), 64'h0A0);
    cyc(1'b1, 1'b1, 12'h0C1);
    chk("clr_first_point", 64'(cnt_point), 64'd1);
    chk("clr_first_data",  64'(word(0, 0)), 64'h0C1);

    // clear honoured while frozen.
    freeze = 1'b1; clear = 1'b1; u_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    freeze = 1'b0; clear = 1'b0; u_if.in_valid = 1'b0;
    chk("frzclr_point", 64'(cnt_point), 64'd0);

    // rst mid-sweep with a sample pending.
    cyc(1'b1, 1'b1, 12'h0D1);
    cyc(1'b1, 1'b0, 12'h0D2);
    chk("rst2_pre_point", 64'(cnt_point), 64'd2);
    rst = 1'b1; u_if.in_valid = 1'b1; u_if.in_data = 12'h0EE;
    #1;
    chk("rst2_ready", 64'(u_if.in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; u_if.in_valid = 1'b0;
    chk("rst2_stor",   64'(|storage), 64'd0);
    chk("rst2_point",  64'(cnt_point), 64'd0);
    chk("rst2_slot",   64'(cnt_slot), 64'd0);
    chk("rst2_filled", 64'(filled), 64'd0);
    cyc(1'b1, 1'b0, 12'h055);
    chk("rst2_discard", 64'(|storage), 64'd0);
    sweep(5, 0);
    chk("rst2_slot_after",   64'(cnt_slot), 64'd1);
    chk("rst2_filled_after", 64'(filled), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
